// File: rtl/rn_dp_queue_pkg.sv
// rtl/rn_dp_queue_pkg.sv - shared widths and helpers for the RN->DP elastic queue
package rn_dp_queue_pkg;

   localparam int RNDP_PAYLOAD_W = 128;
   localparam int RNDP_DEPTH     = 4;

   // Occupancy needs one bit more than the pointers so that DEPTH itself is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rn_dp_ptr.sv
// rtl/rn_dp_ptr.sv - wrapping queue pointer with clear and increment
module rn_dp_ptr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // DEPTH is a power of two, so plain binary overflow is the modulo wrap.
   always_ff @(posedge clk) begin
      if (rst || clear)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/rn_dp_queue.sv
// rtl/rn_dp_queue.sv - in-order DEPTH-entry elastic buffer between rename and dispatch
module rn_dp_queue
   import rn_dp_queue_pkg::*;
#(
   parameter int PAYLOAD_W = RNDP_PAYLOAD_W,
   parameter int DEPTH     = RNDP_DEPTH,
   parameter int AFULL_TH  = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       EN,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PAYLOAD_W-1:0]       in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PAYLOAD_W-1:0]       out_data,
   output logic [cnt_w(DEPTH)-1:0]    count,
   output logic                       almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);

   logic [PAYLOAD_W-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 push;
   logic                 pop;

   // in_ready looks only at local occupancy, never at out_ready, to avoid a ready chain.
   assign in_ready    = (count != FULL_CNT) && !rst;
   assign out_valid   = (count != '0);
   assign out_data    = out_valid ? mem[rd_ptr] : '0;
   assign almost_full = (count >= AF_CNT);

   assign push = EN && in_valid && in_ready && !flush;
   assign pop  = EN && out_valid && out_ready && !flush;

   rn_dp_ptr #(.W(AW)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .inc   (push),
      .ptr   (wr_ptr)
   );

   rn_dp_ptr #(.W(AW)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .inc   (pop),
      .ptr   (rd_ptr)
   );

   // Flop array rather than RAM: the head is read combinationally into dispatch.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_rn_dp_queue.sv
// tb/tb_rn_dp_queue.sv - randomized and directed checks of rn_dp_queue against a queue model
module tb_rn_dp_queue;

   localparam int PW = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] out_data;
   logic [2:0]    count;
   logic          almost_full;

   int checks = 0;
   int passed = 0;
   logic [PW-1:0] model_q[$];

   always #5 clk = ~clk;

   rn_dp_queue #(.PAYLOAD_W(PW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .EN          (en),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .count       (count),
      .almost_full (almost_full)
   );

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
   endtask

   // Compare outputs with the model, then advance the model by the rules of one clock edge.
   task automatic step();
      int  n;
      logic do_push, do_pop;
      #1;
      n = model_q.size();
      chk("count",       PW'(count),       PW'(n));
      chk("out_valid",   PW'(out_valid),   PW'(n != 0));
      chk("out_data",    out_data,         (n != 0) ? model_q[0] : '0);
      chk("in_ready",    PW'(in_ready),    PW'(!rst && n < DEPTH));
      chk("almost_full", PW'(almost_full), PW'(n >= DEPTH - 1));
      if (rst || flush) begin
         model_q.delete();
      end else begin
         do_pop  = en && n > 0 && out_ready;
         do_push = en && in_valid && n < DEPTH;
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(in_data);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held three cycles with in_valid high.
      in_valid = 1'b1;
      in_data  = 32'hDEAD;
      @(posedge clk);
      #1;
      repeat (3) step();
      rst = 1'b0;
      in_valid = 1'b0;
      step();

      // Fill to full with the head stalled, try a fifth push, then drain.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 32'hA1 + i;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();

      // Streaming: pointers wrap several times.
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 32'h100 + i;
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();

      // Stall hold: B1,B2 queued, B3 pushed while out_ready low.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data = 32'hB1; step();
      in_data = 32'hB2; step();
      in_data = 32'hB3; step();
      in_valid = 1'b0;
      repeat (4) step();

      // Flush with a concurrent push and pop; C9 must vanish and D1 lead.
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hC9; out_ready = 1'b1;
      step();
      flush = 1'b0; in_data = 32'hD1; out_ready = 1'b0;
      step();
      in_data = 32'hD2;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();

      // EN low freezes state; flush still empties.
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 32'hE1; step();
      in_data = 32'hE2; step();
      en = 1'b0; out_ready = 1'b1; in_data = 32'hE3;
      repeat (4) step();
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();
      en = 1'b1;

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 7) != 0);
         in_valid  = $urandom_range(0, 1);
         out_ready = $urandom_range(0, 2) != 0;
         flush     = ($urandom_range(0, 29) == 0);
         rst       = ($urandom_range(0, 79) == 0);
         in_data   = $urandom;
         step();
      end
      rst = 1'b0; flush = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
